output_mem_if: RTL

//  Write-side counterpart of the input/weight BRAM readers: collects MAC results from two

---
 rtl/output_mem_if_if.sv | 31 +++
 rtl/output_mem_if.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_mem_if_if.sv
`default_nettype none
// ============================================================================
// output_mem_if_if : result-stream and BRAM write-port bundle for output_mem_if
// Revision: 1.0
// ============================================================================
interface output_mem_if_if #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 16,
  parameter int BRAM_W = 64,
  parameter int AW     = 8
);
  logic [1:0]               in_valid;
  logic [1:0]               in_ready;
  logic [ACC_W-1:0]         in_data0;
  logic [ACC_W-1:0]         in_data1;
  logic [AW-1:0]            bram_addr;
  logic                     bram_en;
  logic [BRAM_W/DATA_W-1:0] bram_we;
  logic [BRAM_W-1:0]        bram_din;

  modport master (
    output in_valid, in_data0, in_data1,
    input  in_ready, bram_addr, bram_en, bram_we, bram_din
  );

  modport slave (
    input  in_valid, in_data0, in_data1,
    output in_ready, bram_addr, bram_en, bram_we, bram_din
  );
endinterface
`default_nettype wire

// File: rtl/output_mem_if.sv
`default_nettype none
// ============================================================================
// output_mem_if : packs two lanes of MAC results into BRAM rows (col0/col1).
// Optional macro OUT_SAT_EN: signed saturation of results plus sat_flag port.
// Revision: 1.0
// ============================================================================
module output_mem_if #(
  parameter int N         = 4,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int BRAM_W    = 64,
  parameter int MEM_DEPTH = 256,
  localparam int c_AW     = $clog2(MEM_DEPTH)
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            start,
  input  wire logic [c_AW-1:0] base_addr,
  output logic                 busy,
  output logic                 done,
`ifdef OUT_SAT_EN
  output logic                 sat_flag,
`endif
  output_mem_if_if.slave       bus
);

  localparam int c_WPB    = BRAM_W / DATA_W;
  localparam int c_RPC    = (N + c_WPB - 1) / c_WPB;
  localparam int c_CNT_W  = $clog2(N + 1);
  localparam int c_SLOT_W = (c_WPB > 1) ? $clog2(c_WPB) : 1;
  localparam int c_ROW_W  = $clog2(c_RPC + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;

`ifdef OUT_SAT_EN
  localparam logic [ACC_W-1:0] c_SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_SMIN = ~c_SMAX;

  function automatic logic f_ovf(input logic [ACC_W-1:0] d);
    return ($signed(d) > $signed(c_SMAX)) || ($signed(d) < $signed(c_SMIN));
  endfunction

  function automatic logic [DATA_W-1:0] f_conv(input logic [ACC_W-1:0] d);
    if ($signed(d) > $signed(c_SMAX)) return {1'b0, {(DATA_W-1){1'b1}}};
    if ($signed(d) < $signed(c_SMIN)) return {1'b1, {(DATA_W-1){1'b0}}};
    return DATA_W'(d);
  endfunction
`else
  function automatic logic [DATA_W-1:0] f_conv(input logic [ACC_W-1:0] d);
    return DATA_W'(d);
  endfunction
`endif

  logic [1:0]        r_state;
  logic [c_AW-1:0]   r_base;
  logic              r_done;
  logic [c_AW-1:0]   r_bram_addr;
  logic [c_WPB-1:0]  r_bram_we;
  logic [BRAM_W-1:0] r_bram_din;

  logic              w_start;
  logic [1:0]        w_ready;
  logic [1:0]        w_full;
  logic [1:0]        w_pend;
  logic [1:0]        w_drain;
  logic              w_sel1;
  logic [c_WPB-1:0]  w_wr_mask;
  logic [BRAM_W-1:0] w_wr_data;
  logic [c_ROW_W-1:0] w_wr_row;
  logic [31:0]       w_addr_sum;

  assign w_start = (r_state == c_IDLE) && start;

  // Per-lane packing: row buffer fills slot by slot, full rows park in a pending register
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [c_CNT_W-1:0]  r_wcnt;
    logic [c_SLOT_W-1:0] r_slot;
    logic [c_ROW_W-1:0]  r_row;
    logic [BRAM_W-1:0]   r_buf;
    logic [c_WPB-1:0]    r_mask;
    logic                r_pend;
    logic [BRAM_W-1:0]   r_pend_data;
    logic [c_WPB-1:0]    r_pend_mask;
    logic [c_ROW_W-1:0]  r_pend_row;
    logic [ACC_W-1:0]    w_raw;
    logic                w_last;
    logic                w_acc;
    logic [BRAM_W-1:0]   w_buf_next;
    logic [c_WPB-1:0]    w_mask_next;

    assign w_raw  = (l == 0) ? bus.in_data0 : bus.in_data1;
    assign w_last = (int'(r_slot) == c_WPB - 1) || (int'(r_wcnt) == N - 1);
    // A row-completing word is held off until the previous row has left pending
    assign w_ready[l] = (r_state == c_RUN) && (int'(r_wcnt) < N) && !(w_last && r_pend);
    assign w_acc      = bus.in_valid[l] && w_ready[l];
    assign w_full[l]  = (int'(r_wcnt) == N);
    assign w_pend[l]  = r_pend;

    always_comb begin
      w_buf_next  = r_buf;
      w_mask_next = r_mask;
      w_buf_next[int'(r_slot)*DATA_W +: DATA_W] = f_conv(w_raw);
      w_mask_next[r_slot] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wcnt      <= '0;
        r_slot      <= '0;
        r_row       <= '0;
        r_buf       <= '0;
        r_mask      <= '0;
        r_pend      <= 1'b0;
        r_pend_data <= '0;
        r_pend_mask <= '0;
        r_pend_row  <= '0;
      end else begin
        if (w_drain[l]) r_pend <= 1'b0;
        if (w_start) begin
          r_wcnt <= '0;
          r_slot <= '0;
          r_row  <= '0;
          r_buf  <= '0;
          r_mask <= '0;
        end else if (w_acc) begin
          r_wcnt <= r_wcnt + 1'b1;
          if (w_last) begin
            r_pend      <= 1'b1;
            r_pend_data <= w_buf_next;
            r_pend_mask <= w_mask_next;
            r_pend_row  <= r_row;
            r_buf       <= '0;
            r_mask      <= '0;
            r_slot      <= '0;
            r_row       <= r_row + 1'b1;
          end else begin
            r_buf  <= w_buf_next;
            r_mask <= w_mask_next;
            r_slot <= r_slot + 1'b1;
          end
        end
      end
    end
  end

  // Write-port arbitration: lane0 wins, lane1 goes the following cycle
  always_comb begin
    w_sel1  = !w_pend[0];
    w_drain = w_pend[0] ? 2'b01 : {w_pend[1], 1'b0};
    if (w_sel1) begin
      w_wr_mask = g_lane[1].r_pend_mask;
      w_wr_data = g_lane[1].r_pend_data;
      w_wr_row  = g_lane[1].r_pend_row;
    end else begin
      w_wr_mask = g_lane[0].r_pend_mask;
      w_wr_data = g_lane[0].r_pend_data;
      w_wr_row  = g_lane[0].r_pend_row;
    end
    w_addr_sum = 32'(r_base) + (w_sel1 ? 32'(c_RPC) : 32'd0) + 32'(w_wr_row);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_base      <= '0;
      r_done      <= 1'b0;
      r_bram_addr <= '0;
      r_bram_we   <= '0;
      r_bram_din  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state <= c_RUN;
            r_base  <= base_addr;
          end
        end
        c_RUN: begin
          if (&w_full) r_state <= c_FLUSH;
        end
        c_FLUSH: begin
          if (!(|w_pend)) begin
            r_state <= c_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase

      r_bram_we <= (|w_pend) ? w_wr_mask : '0;
      if (|w_pend) begin
        r_bram_addr <= c_AW'(w_addr_sum % 32'(MEM_DEPTH));
        r_bram_din  <= w_wr_data;
      end
    end
  end

`ifdef OUT_SAT_EN
  logic       r_sat;
  logic [1:0] w_ovf;

  assign w_ovf = {f_ovf(bus.in_data1), f_ovf(bus.in_data0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_start) begin
      r_sat <= 1'b0;
    end else if (|(bus.in_valid & w_ready & w_ovf)) begin
      r_sat <= 1'b1;
    end
  end

  assign sat_flag = r_sat;
`endif

  assign bus.in_ready  = w_ready;
  assign bus.bram_addr = r_bram_addr;
  assign bus.bram_we   = r_bram_we;
  assign bus.bram_din  = r_bram_din;
  assign bus.bram_en   = |r_bram_we;
  assign busy          = (r_state != c_IDLE);
  assign done          = r_done;

endmodule
`default_nettype wire
